// File: rtl/rob_scheduler.sv
// rob_scheduler: allocation and commit sequencer for an interleaved reorder buffer.
// The ROB is spread across CHANNELS FIFOs. Reorder IDs are {slot, channel}.
// Dispatch slots go to consecutive channels, starting at the tail channel.
// Commit retires in program order, starting at the head channel.
// An excepting commit is followed by a one-cycle FLUSH state that returns both pointers to 0.
module rob_scheduler #(
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 8,
    parameter int ISSUE_NUM  = 2,
    parameter int COMMIT_NUM = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [ISSUE_NUM-1:0]               alloc_req,
    output logic                               alloc_ready,
    output logic [ISSUE_NUM*($clog2(CHANNELS)+$clog2(DEPTH))-1:0] alloc_id,
    input  logic [CHANNELS-1:0]                chan_full,
    input  logic [CHANNELS-1:0]                chan_empty,
    input  logic [CHANNELS-1:0]                chan_head_busy,
    input  logic [CHANNELS-1:0]                chan_head_ex,
    input  logic [CHANNELS*$clog2(DEPTH)-1:0]  chan_wptr,
    output logic [CHANNELS-1:0]                chan_push,
    output logic [CHANNELS-1:0]                chan_pop,
    input  logic                               commit_stall,
    output logic [COMMIT_NUM-1:0]              commit_valid,
    output logic [COMMIT_NUM*$clog2(CHANNELS)-1:0] commit_chan,
    output logic                               flush_o
);

    localparam int CW    = $clog2(CHANNELS);
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = CW + AW;
    localparam int CNT_W = CW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     tail_ch_reg, tail_ch_next;
    logic [CW-1:0]     head_ch_reg, head_ch_next;
    logic              flush_o_reg, flush_o_next;

    // Normal operation is possible only in RUN, outside reset, with no flush pending.
    // Any of these conditions quiets every combinational grant.
    logic run_active;
    logic commit_en;

    assign run_active = !rst && !flush && (state_reg == RUN) && !flush_o_reg;
    assign commit_en  = run_active && !commit_stall;

    // Write pointer of each channel, unpacked from the flat input bus.
    logic [AW-1:0] wptr_arr [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_wptr
        assign wptr_arr[gi] = chan_wptr[gi*AW +: AW];
    end

    // ------------------------------------------------------------------
    // Allocation: slot k targets channel tail+k, wrapping at CW bits.
    // ------------------------------------------------------------------
    logic [CW-1:0]        alloc_tgt [ISSUE_NUM];
    logic [ISSUE_NUM-1:0] slot_blocked;
    logic [CNT_W-1:0]     alloc_cnt;

    for (genvar gi = 0; gi < ISSUE_NUM; gi++) begin : g_alloc
        assign alloc_tgt[gi]            = tail_ch_reg + CW'(gi);
        assign slot_blocked[gi]         = alloc_req[gi] & chan_full[alloc_tgt[gi]];
        assign alloc_id[gi*RW +: RW]    = {wptr_arr[alloc_tgt[gi]], alloc_tgt[gi]};
    end

    // Grant is all-or-nothing: a single full target channel rejects the whole group.
    assign alloc_ready = run_active && !(|slot_blocked);

    // Decode the granted slots into per-channel pushes and count them for the tail advance.
    always_comb begin
        chan_push = '0;
        alloc_cnt = '0;
        if (alloc_ready) begin
            for (int k = 0; k < ISSUE_NUM; k++) begin
                if (alloc_req[k]) begin
                    chan_push[alloc_tgt[k]] = 1'b1;
                    alloc_cnt               = alloc_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit: slot k examines channel head+k, retiring in order.
    // ------------------------------------------------------------------
    logic [CW-1:0]         commit_src [COMMIT_NUM];
    logic [COMMIT_NUM-1:0] slot_ok;
    logic [COMMIT_NUM-1:0] slot_ex;
    logic [COMMIT_NUM-1:0] commit_vec;
    logic [CNT_W-1:0]      commit_cnt;
    logic                  except_commit;

    for (genvar gi = 0; gi < COMMIT_NUM; gi++) begin : g_commit
        assign commit_src[gi]            = head_ch_reg + CW'(gi);
        assign slot_ok[gi]               = commit_en & ~chan_empty[commit_src[gi]]
                                                     & ~chan_head_busy[commit_src[gi]];
        assign slot_ex[gi]               = chan_head_ex[commit_src[gi]];
        assign commit_chan[gi*CW +: CW]  = commit_src[gi];
    end

    // Slot 0 needs only a ready head.
    // Later slots need every earlier slot to commit, and no exception on either side of the link.
    // As a result, an excepting entry retires only in slot 0 and retires alone.
    assign commit_vec[0] = slot_ok[0];

    for (genvar gi = 1; gi < COMMIT_NUM; gi++) begin : g_chain
        assign commit_vec[gi] = commit_vec[gi-1] & slot_ok[gi] & ~slot_ex[gi-1] & ~slot_ex[gi];
    end

    assign commit_valid  = commit_vec;
    assign except_commit = commit_vec[0] & slot_ex[0];

    // Decode the retiring slots into per-channel pops and count them for the head advance.
    always_comb begin
        chan_pop   = '0;
        commit_cnt = '0;
        for (int k = 0; k < COMMIT_NUM; k++) begin
            if (commit_vec[k]) begin
                chan_pop[commit_src[k]] = 1'b1;
                commit_cnt              = commit_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM and pointer updates.
    // ------------------------------------------------------------------

    // Next-state logic.
    // The external flush overrides everything.
    // The FLUSH state lasts exactly one cycle, then parks both pointers at 0.
    always_comb begin
        state_next   = state_reg;
        tail_ch_next = tail_ch_reg;
        head_ch_next = head_ch_reg;
        flush_o_next = flush_o_reg;
        if (flush) begin
            state_next   = RUN;
            tail_ch_next = '0;
            head_ch_next = '0;
            flush_o_next = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (alloc_ready) begin
                        tail_ch_next = tail_ch_reg + alloc_cnt[CW-1:0];
                    end
                    head_ch_next = head_ch_reg + commit_cnt[CW-1:0];
                    if (except_commit) begin
                        state_next   = FLUSH;
                        flush_o_next = 1'b1;
                    end
                end
                FLUSH: begin
                    state_next   = RUN;
                    tail_ch_next = '0;
                    head_ch_next = '0;
                    flush_o_next = 1'b0;
                end
                default: begin
                    state_next   = RUN;
                    tail_ch_next = '0;
                    head_ch_next = '0;
                    flush_o_next = 1'b0;
                end
            endcase
        end
    end

    // State and pointer registers. Reset clears them immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RUN;
            tail_ch_reg <= '0;
            head_ch_reg <= '0;
            flush_o_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tail_ch_reg <= tail_ch_next;
            head_ch_reg <= head_ch_next;
            flush_o_reg <= flush_o_next;
        end
    end

    assign flush_o = flush_o_reg;

endmodule
